// File: rtl/store_data_aligner_if.sv
// -----------------------------------------------------------------------------
// store_data_aligner_if
//
// Bundles the store-request handshake (execute stage -> aligner) and the data
// memory write-beat handshake (aligner -> data memory) into one interface.
//
// Parameters:
//   ADDR_W      byte-address width
//
// Signals:
//   req_valid   store request valid
//   req_ready   aligner can accept a request
//   req_addr    byte address of the store
//   req_wdata   register value to store (rs2)
//   req_size    00=byte, 01=half, 10=word, 11=illegal
//   mem_valid   write beat valid
//   mem_ready   memory accepts the beat
//   mem_addr    word-aligned write address
//   mem_wdata   lane-placed write data
//   mem_be      byte enables, bit i = lane i
//
// Modports:
//   slave   the aligner: consumes requests, produces memory beats
//   master  the surrounding environment: issues requests, sinks beats
// -----------------------------------------------------------------------------
interface store_data_aligner_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_data_aligner.sv
// -----------------------------------------------------------------------------
// store_data_aligner
//
// Narrows a 32-bit register value into SB/SH/SW byte lanes with byte enables,
// word-aligns the address and issues the write to data memory over a
// valid/ready handshake.
//
// Parameters:
//   ADDR_W        byte-address width (mem_addr wraps modulo 2^ADDR_W)
//   DATA_W        data width, only 32 (4 byte lanes) is supported
//
// Ports:
//   clk           clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   bus           store_data_aligner_if.slave (request + memory handshakes)
//   misalign_err  one-cycle pulse the cycle after a rejected request
//   busy          high whenever a beat is being presented (state != IDLE)
//
// Optional feature (macro MISALIGN_SPLIT_EN):
//   When defined, a misaligned half/word is split into two beats (the aligned
//   word and the following word) instead of being rejected. Illegal size 11
//   is rejected in both builds.
// -----------------------------------------------------------------------------
module store_data_aligner #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    store_data_aligner_if.slave bus,
    output logic               misalign_err,
    output logic               busy
);

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, SEND2 = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

    state_t              state_reg, state_next;

    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [3:0]          mem_be_reg;
    logic                err_reg;

    logic                req_ready;
    logic                accept;
    logic                reject;
    logic                misaligned;
    logic [1:0]          off;
    logic [ADDR_W-1:0]   word_addr;
    logic [3:0]          size_mask;
    logic [DATA_W-1:0]   repl_data;
    logic [DATA_W-1:0]   lane_data;
    logic [3:0]          lane_be;

    assign req_ready = (state_reg == IDLE);
    assign accept    = bus.req_valid && req_ready;
    assign off       = bus.req_addr[1:0];
    assign word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};

    assign misaligned = ((bus.req_size == 2'b01) && off[0]) ||
                        ((bus.req_size == 2'b10) && (off != 2'b00));

    always_comb begin
        size_mask = 4'b0000;
        repl_data = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                size_mask = 4'b0001;
                repl_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                size_mask = 4'b0011;
                repl_data = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                size_mask = 4'b1111;
                repl_data = bus.req_wdata;
            end
            default: begin
                size_mask = 4'b0000;
                repl_data = bus.req_wdata;
            end
        endcase
    end

`ifdef MISALIGN_SPLIT_EN
    // Shifting into a double-width window gives both beats at once: the low
    // half is the first word, whatever spills into the high half is the
    // second word.
    logic [2*DATA_W-1:0] data_wide;
    logic [7:0]          be_wide;
    logic                has_second;
    logic                split_reg;
    logic [ADDR_W-1:0]   pend_addr_reg;
    logic [DATA_W-1:0]   pend_wdata_reg;
    logic [3:0]          pend_be_reg;

    assign data_wide  = {{DATA_W{1'b0}}, bus.req_wdata} << {off, 3'b000};
    assign be_wide    = {4'b0000, size_mask} << off;
    assign has_second = (be_wide[7:4] != 4'b0000);
    assign reject     = (bus.req_size == 2'b11);
    assign lane_be    = be_wide[3:0];
    // Aligned requests keep the replicated form so unused lanes are defined.
    assign lane_data  = misaligned ? data_wide[DATA_W-1:0] : repl_data;
`else
    assign reject     = (bus.req_size == 2'b11) || misaligned;
    assign lane_be    = size_mask << off;
    assign lane_data  = repl_data;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && !reject) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bus.mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
                    state_next = split_reg ? SEND2 : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            SEND2: begin
                if (bus.mem_ready) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Beat registers: loaded on accept, and (split build) reloaded with the
    // second beat when the first one is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_be_reg     <= 4'b0000;
            err_reg        <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            split_reg      <= 1'b0;
            pend_addr_reg  <= '0;
            pend_wdata_reg <= '0;
            pend_be_reg    <= 4'b0000;
`endif
        end else begin
            err_reg <= accept && reject;
            if (accept && !reject) begin
                mem_addr_reg  <= word_addr;
                mem_wdata_reg <= lane_data;
                mem_be_reg    <= lane_be;
`ifdef MISALIGN_SPLIT_EN
                split_reg      <= has_second;
                pend_addr_reg  <= word_addr + ADDR_W'(4);
                pend_wdata_reg <= data_wide[2*DATA_W-1:DATA_W];
                pend_be_reg    <= be_wide[7:4];
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            else if ((state_reg == SEND) && bus.mem_ready && split_reg) begin
                mem_addr_reg  <= pend_addr_reg;
                mem_wdata_reg <= pend_wdata_reg;
                mem_be_reg    <= pend_be_reg;
                split_reg     <= 1'b0;
            end
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mem_valid = (state_reg != IDLE);
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_be    = mem_be_reg;
    assign misalign_err  = err_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_store_data_aligner.sv
// -----------------------------------------------------------------------------
// tb_store_data_aligner
//
// Scoreboard bench for store_data_aligner. Each accepted request is expanded
// by a byte-level reference model (store byte k of the value at byte address
// addr+k, then group bytes by word) into expected beats or an expected error
// pulse. A monitor pops and compares whenever a beat transfers or
// misalign_err pulses. Build with +define+MISALIGN_SPLIT_EN to test the split
// variant.
// -----------------------------------------------------------------------------
module tb_store_data_aligner;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic misalign_err;
    logic busy;

    store_data_aligner_if #(.ADDR_W(ADDR_W)) bus ();

    store_data_aligner #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .misalign_err (misalign_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef struct {
        bit          err;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          full;   // compare all lanes, not just enabled ones
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ready_mode = 1;    // 0 = hold low, 1 = hold high, 2 = random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Byte-level reference model.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        exp_t        beats[2];
        int          nbytes;
        logic [31:0] b;
        logic [31:0] w0;
        bit          misal;
        if (s == 2'b11) begin
            sb.push_back('{err: 1'b1, addr: 32'h0, data: 32'h0, be: 4'h0, full: 1'b0});
            return;
        end
        nbytes = 1 << s;
        misal  = (a % nbytes) != 0;
        if (misal && !SPLIT_EN) begin
            sb.push_back('{err: 1'b1, addr: 32'h0, data: 32'h0, be: 4'h0, full: 1'b0});
            return;
        end
        w0 = a & ~32'h3;
        beats[0] = '{err: 1'b0, addr: w0, data: 32'h0, be: 4'h0, full: !misal};
        beats[1] = '{err: 1'b0, addr: w0 + 32'd4, data: 32'h0, be: 4'h0, full: 1'b0};
        for (int k = 0; k < nbytes; k++) begin
            b = a + k;
            if ((b & ~32'h3) == w0) begin
                beats[0].be[b[1:0]] = 1'b1;
                beats[0].data[b[1:0]*8 +: 8] = d[k*8 +: 8];
            end else begin
                beats[1].be[b[1:0]] = 1'b1;
                beats[1].data[b[1:0]*8 +: 8] = d[k*8 +: 8];
            end
        end
        // Aligned stores replicate the value across every lane.
        if (!misal) begin
            for (int l = 0; l < 4; l++) beats[0].data[l*8 +: 8] = d[(l % nbytes)*8 +: 8];
        end
        sb.push_back(beats[0]);
        if (beats[1].be != 4'h0) sb.push_back(beats[1]);
    endtask

    // mem_ready driver, applied a little after each rising edge.
    initial begin
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.mem_ready = 1'b0;
                1:       bus.mem_ready = 1'b1;
                default: bus.mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every transferred beat and every error pulse.
    initial begin
        exp_t        e;
        logic [31:0] m;
        bit          prev_stall;
        logic [31:0] prev_addr, prev_data;
        logic [3:0]  prev_be;
        prev_stall = 1'b0;
        prev_addr = '0; prev_data = '0; prev_be = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(bus.mem_valid), 32'd1);
                    chk("hold_addr", bus.mem_addr, prev_addr);
                    chk("hold_data", bus.mem_wdata, prev_data);
                    chk("hold_be", 32'(bus.mem_be), 32'(prev_be));
                end
                if (bus.mem_valid && bus.mem_ready) begin
                    $display("beat addr=%08h data=%08h be=%b", bus.mem_addr, bus.mem_wdata, bus.mem_be);
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_beat: got addr 0x%08h required no beat", bus.mem_addr);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_kind", 32'(e.err), 32'd0);
                        chk("beat_addr", bus.mem_addr, e.addr);
                        chk("beat_be", 32'(bus.mem_be), 32'(e.be));
                        m = e.full ? 32'hFFFF_FFFF
                                   : {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
                        chk("beat_data", bus.mem_wdata & m, e.data & m);
                    end
                end
                if (misalign_err) begin
                    $display("misalign_err pulse");
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_err: got misalign_err=1 required 0");
                    end else begin
                        e = sb.pop_front();
                        chk("err_kind", 32'(e.err), 32'd1);
                    end
                end
                prev_stall = bus.mem_valid && !bus.mem_ready;
                prev_addr  = bus.mem_addr;
                prev_data  = bus.mem_wdata;
                prev_be    = bus.mem_be;
            end
        end
    end

    // Issue one request; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int w = 0;
        @(posedge clk);
        #1;
        while (!bus.req_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!bus.req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL req_ready_timeout: got req_ready=0 required 1 within 100 cycles");
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_size  = s;
        @(posedge clk);
        model(a, d, s);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_size  = 2'($urandom_range(0, 3));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          w;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_size  = 2'b00;
        ready_mode    = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_err", 32'(misalign_err), 32'd0);

        // SB to the top byte lane, one-cycle latency
        ready_mode = 1;
        issue(32'h0000_0103, 32'hDEAD_BEEF, 2'b00);
        chk("sb_valid", 32'(bus.mem_valid), 32'd1);
        chk("sb_addr", bus.mem_addr, 32'h0000_0100);
        chk("sb_data", bus.mem_wdata, 32'hEFEF_EFEF);
        chk("sb_be", 32'(bus.mem_be), 32'h8);
        chk("sb_req_ready", 32'(bus.req_ready), 32'd0);

        // SH with memory stalled three cycles
        @(posedge clk); #1;
        ready_mode = 0;
        issue(32'h0000_0202, 32'h1234_ABCD, 2'b01);
        for (int i = 0; i < 3; i++) begin
            chk("sh_valid", 32'(bus.mem_valid), 32'd1);
            chk("sh_addr", bus.mem_addr, 32'h0000_0200);
            chk("sh_data", bus.mem_wdata, 32'hABCD_ABCD);
            chk("sh_be", 32'(bus.mem_be), 32'hC);
            chk("sh_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        ready_mode = 1;
        @(posedge clk); #1;
        chk("sh_done_valid", 32'(bus.mem_valid), 32'd0);
        chk("sh_done_ready", 32'(bus.req_ready), 32'd1);

        // Misaligned word
        issue(32'h0000_0301, 32'h0BAD_F00D, 2'b10);
`ifdef MISALIGN_SPLIT_EN
        chk("sw_mis_valid", 32'(bus.mem_valid), 32'd1);
        chk("sw_mis_err", 32'(misalign_err), 32'd0);
        chk("sw_mis_be1", 32'(bus.mem_be), 32'hE);
`else
        chk("sw_mis_err", 32'(misalign_err), 32'd1);
        chk("sw_mis_valid", 32'(bus.mem_valid), 32'd0);
        chk("sw_mis_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        chk("sw_mis_err_pulse", 32'(misalign_err), 32'd0);
        chk("sw_mis_valid2", 32'(bus.mem_valid), 32'd0);
`endif
        w = 0;
        while (busy && w < 20) begin @(posedge clk); #1; w++; end

        // Illegal size
        issue(32'h0000_0000, 32'h5555_AAAA, 2'b11);
        chk("ill_err", 32'(misalign_err), 32'd1);
        chk("ill_valid", 32'(bus.mem_valid), 32'd0);
        chk("ill_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        chk("ill_err_pulse", 32'(misalign_err), 32'd0);

        // Word straddling the top of the address space
        ready_mode = 0;
        issue(32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b10);
`ifdef MISALIGN_SPLIT_EN
        chk("wrap_b1_addr", bus.mem_addr, 32'hFFFF_FFFC);
        chk("wrap_b1_be", 32'(bus.mem_be), 32'hC);
        chk("wrap_b1_data", 32'(bus.mem_wdata[31:16]), 32'hCCDD);
        ready_mode = 1;
        @(posedge clk); #1;
        chk("wrap_b2_valid", 32'(bus.mem_valid), 32'd1);
        chk("wrap_b2_addr", bus.mem_addr, 32'h0000_0000);
        chk("wrap_b2_be", 32'(bus.mem_be), 32'h3);
        chk("wrap_b2_data", 32'(bus.mem_wdata[15:0]), 32'hAABB);
`else
        chk("wrap_err", 32'(misalign_err), 32'd1);
        ready_mode = 1;
`endif
        w = 0;
        while (busy && w < 20) begin @(posedge clk); #1; w++; end

        // Asynchronous reset in the middle of a stalled beat
        ready_mode = 0;
        issue(32'h0000_0040, 32'h1122_3344, 2'b10);
        chk("pre_rst_valid", 32'(bus.mem_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.mem_valid), 32'd0);
        chk("arst_be", 32'(bus.mem_be), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        ready_mode = 1;
        @(posedge clk); #3 rst_n = 1'b1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_no_beat", 32'(bus.mem_valid), 32'd0);
        end

        // Randomized traffic with random back-pressure
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31:4] = '1;
            issue(a, $urandom, 2'($urandom_range(0, 3)));
        end

        // Drain
        ready_mode = 1;
        w = 0;
        while ((sb.size() != 0 || busy) && w < 1000) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
